// File: rtl/rgb_seq_pkg.sv
// Shared definitions for the RGB hue-wheel sequencer.
//   - state_t : controller state encoding (IDLE / RUN)
//   - PH_*    : hue phase encoding, 0..5, named after the constant channel
//               and the channel that ramps in that phase
//   - CH_*    : bit index of each colour in the rgb output bus
package rgb_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] PH_R_GUP = 3'd0;  // R at MAX, G ramps up
  localparam logic [2:0] PH_G_RDN = 3'd1;  // G at MAX, R ramps down
  localparam logic [2:0] PH_G_BUP = 3'd2;  // G at MAX, B ramps up
  localparam logic [2:0] PH_B_GDN = 3'd3;  // B at MAX, G ramps down
  localparam logic [2:0] PH_B_RUP = 3'd4;  // B at MAX, R ramps up
  localparam logic [2:0] PH_R_BDN = 3'd5;  // R at MAX, B ramps down

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;

endpackage

// File: rtl/rgb_sequencer_pwm_channel.sv
// One PWM output channel: registered compare of the shared counter
// against this channel's duty value.
// Ports:
//   clk   in   system clock
//   rst_n in   synchronous active-low reset
//   en    in   1 = output may be driven; 0 = output forced low next cycle
//   cnt   in   shared PWM counter (0..MAX-1)
//   duty  in   duty value; 0 = always low, MAX = always high
//   pwm   out  registered (cnt < duty) gated by en
module pwm_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm
);

  // Compare register: one cycle of latency from counter/duty to pin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else begin
      pwm <= en & (cnt < duty);
    end
  end

endmodule

// File: rtl/rgb_sequencer.sv
// Hue-wheel sequencer for the RGB LED. A dwell prescaler produces a
// brightness step every DWELL_TIME clocks; each step moves one channel
// by 1 according to the current phase, and the phase advances as the
// ramping channel reaches its endpoint. Three PWM channels share one
// counter that runs with period MAX.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   en              1 = run and drive LEDs, 0 = LEDs off, state frozen
//   hold            1 = freeze hue (prescaler stopped), PWM keeps running
//   rgb[2:0]        registered PWM pins, [0]=red [1]=green [2]=blue
//   duty_r/g/b      live duty registers
//   phase           live hue phase 0..5
//   wrap            one-cycle pulse when phase returns from 5 to 0
module rgb_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int          PWM_BITS   = 8,
  parameter logic [19:0] DWELL_TIME = 20'd500
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                hold,
  output logic [2:0]          rgb,
  output logic [PWM_BITS-1:0] duty_r,
  output logic [PWM_BITS-1:0] duty_g,
  output logic [PWM_BITS-1:0] duty_b,
  output logic [2:0]          phase,
  output logic                wrap
);

  localparam logic [PWM_BITS-1:0] MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};

  state_t              state_r, next_state_s;
  logic                run_s, run_next_s;
  logic [19:0]         presc_r;
  logic                count_en_s, step_s;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [PWM_BITS-1:0] red_r, grn_r, blu_r;
  logic [PWM_BITS-1:0] red_nx_s, grn_nx_s, blu_nx_s;
  logic [2:0]          phase_r, phase_nx_s;
  logic                wrap_r, wrap_nx_s;

  function automatic logic [PWM_BITS-1:0] inc_sat(input logic [PWM_BITS-1:0] d);
    if (d == MAX) return d;
    else          return d + ONE;
  endfunction

  function automatic logic [PWM_BITS-1:0] dec_sat(input logic [PWM_BITS-1:0] d);
    if (d == ZERO) return d;
    else           return d - ONE;
  endfunction

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic: en alone selects between the two states.
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (en) next_state_s = RUN;
        else    next_state_s = IDLE;
      end
      RUN: begin
        if (en) next_state_s = RUN;
        else    next_state_s = IDLE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs. The PWM registers are gated with the next state so the
  // pins go dark on the same edge that the FSM drops back to IDLE.
  always_comb begin
    run_s      = (state_r == RUN);
    run_next_s = (next_state_s == RUN);
  end

  // Hold wins over the terminal count, so a held prescaler never steps.
  assign count_en_s = run_s & ~hold;
  assign step_s     = count_en_s & (presc_r == (DWELL_TIME - 20'd1));

  // Dwell prescaler: counts 0..DWELL_TIME-1 while running and not held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_r <= 20'd0;
    end else if (step_s) begin
      presc_r <= 20'd0;
    end else if (count_en_s) begin
      presc_r <= presc_r + 20'd1;
    end else begin
      presc_r <= presc_r;
    end
  end

  // Shared PWM counter: period MAX so that duty=MAX is a constant high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_r <= ZERO;
    end else if (run_s) begin
      if (pwm_cnt_r == (MAX - ONE)) pwm_cnt_r <= ZERO;
      else                          pwm_cnt_r <= pwm_cnt_r + ONE;
    end else begin
      pwm_cnt_r <= pwm_cnt_r;
    end
  end

  // Ramp logic: on a step move the active channel by one; the phase
  // advances on the same edge that the channel reaches its endpoint.
  always_comb begin
    red_nx_s   = red_r;
    grn_nx_s   = grn_r;
    blu_nx_s   = blu_r;
    phase_nx_s = phase_r;
    wrap_nx_s  = 1'b0;
    if (step_s) begin
      case (phase_r)
        PH_R_GUP: begin
          grn_nx_s = inc_sat(grn_r);
          if (grn_nx_s == MAX) phase_nx_s = PH_G_RDN;
          else                 phase_nx_s = phase_r;
        end
        PH_G_RDN: begin
          red_nx_s = dec_sat(red_r);
          if (red_nx_s == ZERO) phase_nx_s = PH_G_BUP;
          else                  phase_nx_s = phase_r;
        end
        PH_G_BUP: begin
          blu_nx_s = inc_sat(blu_r);
          if (blu_nx_s == MAX) phase_nx_s = PH_B_GDN;
          else                 phase_nx_s = phase_r;
        end
        PH_B_GDN: begin
          grn_nx_s = dec_sat(grn_r);
          if (grn_nx_s == ZERO) phase_nx_s = PH_B_RUP;
          else                  phase_nx_s = phase_r;
        end
        PH_B_RUP: begin
          red_nx_s = inc_sat(red_r);
          if (red_nx_s == MAX) phase_nx_s = PH_R_BDN;
          else                 phase_nx_s = phase_r;
        end
        PH_R_BDN: begin
          blu_nx_s = dec_sat(blu_r);
          if (blu_nx_s == ZERO) begin
            phase_nx_s = PH_R_GUP;
            wrap_nx_s  = 1'b1;
          end else begin
            phase_nx_s = phase_r;
          end
        end
        // Unreachable encodings (6, 7) fall back to the start of the wheel.
        default: phase_nx_s = PH_R_GUP;
      endcase
    end else begin
      phase_nx_s = phase_r;
    end
  end

  // Duty, phase and wrap registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      red_r   <= MAX;
      grn_r   <= ZERO;
      blu_r   <= ZERO;
      phase_r <= PH_R_GUP;
      wrap_r  <= 1'b0;
    end else begin
      red_r   <= red_nx_s;
      grn_r   <= grn_nx_s;
      blu_r   <= blu_nx_s;
      phase_r <= phase_nx_s;
      wrap_r  <= wrap_nx_s;
    end
  end

  pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_r (
    .clk(clk), .rst_n(rst_n), .en(run_next_s), .cnt(pwm_cnt_r), .duty(red_r), .pwm(rgb[CH_R])
  );
  pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_g (
    .clk(clk), .rst_n(rst_n), .en(run_next_s), .cnt(pwm_cnt_r), .duty(grn_r), .pwm(rgb[CH_G])
  );
  pwm_channel #(.PWM_BITS(PWM_BITS)) u_pwm_b (
    .clk(clk), .rst_n(rst_n), .en(run_next_s), .cnt(pwm_cnt_r), .duty(blu_r), .pwm(rgb[CH_B])
  );

  assign duty_r = red_r;
  assign duty_g = grn_r;
  assign duty_b = blu_r;
  assign phase  = phase_r;
  assign wrap   = wrap_r;

endmodule

// File: tb/tb_rgb_sequencer.sv
// Scoreboard bench for rgb_sequencer with PWM_BITS=3 (MAX=7), DWELL_TIME=4.
// Stimulus pushes expectations tagged with the cycle they apply to; a
// monitor on the falling edge records outputs and compares due entries.
module tb_rgb_sequencer;

  localparam int          PB = 3;
  localparam logic [19:0] DW = 20'd4;

  logic          clk = 1'b0;
  logic          rst_n, en, hold;
  logic [2:0]    rgb;
  logic [PB-1:0] duty_r, duty_g, duty_b;
  logic [2:0]    phase;
  logic          wrap;

  rgb_sequencer #(.PWM_BITS(PB), .DWELL_TIME(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hold(hold), .rgb(rgb),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b), .phase(phase), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         cyc;
    string      name;
    int         kind;     // 0 = snapshot, 1 = high-count over a window
    logic       chk_rgb;
    logic [2:0] rgb;
    logic [2:0] dr, dg, db, ph;
    logic       w;
    int         bit_i, lo, hi, cnt;
  } exp_t;

  exp_t       q[$];
  logic [3:0] hist [0:1023];  // {wrap, rgb} per cycle

  task automatic snap(input int c, input string nm, input logic chk, input logic [2:0] r,
                      input logic [2:0] dr, input logic [2:0] dg, input logic [2:0] db,
                      input logic [2:0] ph, input logic w);
    exp_t e;
    e.cyc = c; e.name = nm; e.kind = 0; e.chk_rgb = chk; e.rgb = r;
    e.dr = dr; e.dg = dg; e.db = db; e.ph = ph; e.w = w;
    e.bit_i = 0; e.lo = 0; e.hi = 0; e.cnt = 0;
    q.push_back(e);
  endtask

  task automatic count_chk(input int c, input string nm, input int b, input int lo,
                           input int hi, input int n);
    exp_t e;
    e.cyc = c; e.name = nm; e.kind = 1; e.chk_rgb = 1'b0; e.rgb = 3'b000;
    e.dr = 3'd0; e.dg = 3'd0; e.db = 3'd0; e.ph = 3'd0; e.w = 1'b0;
    e.bit_i = b; e.lo = lo; e.hi = hi; e.cnt = n;
    q.push_back(e);
  endtask

  task automatic do_check(input exp_t e);
    int  n;
    logic ok;
    total++;
    if (e.kind == 0) begin
      ok = (duty_r === e.dr) && (duty_g === e.dg) && (duty_b === e.db) &&
           (phase === e.ph) && (wrap === e.w) && (!e.chk_rgb || (rgb === e.rgb));
      if (!ok) begin
        bad++;
        $display("FAIL %s @cyc %0d: got rgb=%b r=%0d g=%0d b=%0d ph=%0d wrap=%b; want rgb=%b(chk=%b) r=%0d g=%0d b=%0d ph=%0d wrap=%b",
                 e.name, cyc, rgb, duty_r, duty_g, duty_b, phase, wrap,
                 e.rgb, e.chk_rgb, e.dr, e.dg, e.db, e.ph, e.w);
      end
    end else begin
      n = 0;
      for (int t = e.lo; t <= e.hi; t++) n += (hist[t][e.bit_i] === 1'b1) ? 1 : 0;
      if (n != e.cnt) begin
        bad++;
        $display("FAIL %s @cyc %0d: bit %0d high %0d times in cycles %0d..%0d, want %0d",
                 e.name, cyc, e.bit_i, n, e.lo, e.hi, e.cnt);
      end
    end
  endtask

  // Monitor: record outputs, then compare every expectation due this cycle.
  always @(negedge clk) begin
    if (cyc < 1024) hist[cyc] = {wrap, rgb};
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        do_check(q[i]);
        q.delete(i);
      end else if (q[i].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s: check for cycle %0d was skipped (now %0d)", q[i].name, q[i].cyc, cyc);
        q.delete(i);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; hold = 1'b0;

    // Reset state.
    wait_cyc(1);
    snap(2, "reset", 1'b1, 3'b000, 3'd7, 3'd0, 3'd0, 3'd0, 1'b0);

    // Release and enable: RUN entered on edge 3, first step on edge 7.
    wait_cyc(2);
    rst_n = 1'b1; en = 1'b1;
    snap(3,   "run_entry",  1'b1, 3'b001, 3'd7, 3'd0, 3'd0, 3'd0, 1'b0);
    snap(6,   "pre_step",   1'b1, 3'b001, 3'd7, 3'd0, 3'd0, 3'd0, 1'b0);
    snap(7,   "first_step", 1'b0, 3'b000, 3'd7, 3'd1, 3'd0, 3'd0, 1'b0);
    count_chk(16, "red_duty7_high", 0, 3, 16, 14);
    count_chk(16, "blue_duty0_low", 2, 3, 16, 0);
    snap(30,  "ph0_end",    1'b0, 3'b000, 3'd7, 3'd6, 3'd0, 3'd0, 1'b0);
    snap(31,  "ph1_start",  1'b0, 3'b000, 3'd7, 3'd7, 3'd0, 3'd1, 1'b0);
    snap(59,  "ph2_start",  1'b0, 3'b000, 3'd0, 3'd7, 3'd0, 3'd2, 1'b0);
    snap(87,  "ph3_start",  1'b0, 3'b000, 3'd0, 3'd7, 3'd7, 3'd3, 1'b0);
    snap(115, "ph4_start",  1'b0, 3'b000, 3'd0, 3'd0, 3'd7, 3'd4, 1'b0);
    snap(143, "ph5_start",  1'b0, 3'b000, 3'd7, 3'd0, 3'd7, 3'd5, 1'b0);
    snap(170, "pre_wrap",   1'b0, 3'b000, 3'd7, 3'd0, 3'd1, 3'd5, 1'b0);
    snap(171, "wrap",       1'b0, 3'b000, 3'd7, 3'd0, 3'd0, 3'd0, 1'b1);
    snap(172, "post_wrap",  1'b0, 3'b000, 3'd7, 3'd0, 3'd0, 3'd0, 1'b0);
    count_chk(172, "wrap_once", 3, 3, 172, 1);

    // Second lap: freeze at duty_g=3 and measure the PWM pattern.
    wait_cyc(182);
    snap(183, "g3_reached", 1'b0, 3'b000, 3'd7, 3'd3, 3'd0, 3'd0, 1'b0);
    wait_cyc(183);
    hold = 1'b1;
    count_chk(203, "pwm_g3_of_7",  1, 190, 196, 3);
    count_chk(203, "pwm_g6_of_14", 1, 190, 203, 6);
    snap(205, "hold_frozen", 1'b0, 3'b000, 3'd7, 3'd3, 3'd0, 3'd0, 1'b0);

    // Hold coincident with terminal count (prescaler reaches 3 on edge 208).
    wait_cyc(205);
    hold = 1'b0;
    wait_cyc(208);
    hold = 1'b1;
    snap(214, "hold_at_tc", 1'b0, 3'b000, 3'd7, 3'd3, 3'd0, 3'd0, 1'b0);
    wait_cyc(214);
    hold = 1'b0;
    snap(215, "release_step", 1'b0, 3'b000, 3'd7, 3'd4, 3'd0, 3'd0, 1'b0);
    snap(227, "ph1_again",    1'b0, 3'b000, 3'd7, 3'd7, 3'd0, 3'd1, 1'b0);
    snap(255, "ph2_again",    1'b0, 3'b000, 3'd0, 3'd7, 3'd0, 3'd2, 1'b0);
    snap(271, "b4",           1'b0, 3'b000, 3'd0, 3'd7, 3'd4, 3'd2, 1'b0);

    // en drop mid phase 2 with prescaler at 2 after edge 273.
    wait_cyc(272);
    en = 1'b0;
    snap(273, "en_off_dark", 1'b1, 3'b000, 3'd0, 3'd7, 3'd4, 3'd2, 1'b0);
    count_chk(293, "idle_red_low",   0, 273, 292, 0);
    count_chk(293, "idle_green_low", 1, 273, 292, 0);
    count_chk(293, "idle_blue_low",  2, 273, 292, 0);
    snap(293, "idle_frozen", 1'b1, 3'b000, 3'd0, 3'd7, 3'd4, 3'd2, 1'b0);
    wait_cyc(293);
    en = 1'b1;
    snap(295, "resume_wait", 1'b0, 3'b000, 3'd0, 3'd7, 3'd4, 3'd2, 1'b0);
    snap(296, "resume_step", 1'b0, 3'b000, 3'd0, 3'd7, 3'd5, 3'd2, 1'b0);
    snap(304, "ph3_again",   1'b0, 3'b000, 3'd0, 3'd7, 3'd7, 3'd3, 1'b0);
    snap(332, "ph4_again",   1'b0, 3'b000, 3'd0, 3'd0, 3'd7, 3'd4, 1'b0);
    snap(341, "ph4_r2",      1'b0, 3'b000, 3'd2, 3'd0, 3'd7, 3'd4, 1'b0);

    // Synchronous reset mid phase 4 while en and hold are high.
    wait_cyc(341);
    rst_n = 1'b0; hold = 1'b1;
    snap(342, "srst",      1'b1, 3'b000, 3'd7, 3'd0, 3'd0, 3'd0, 1'b0);
    snap(344, "srst_held", 1'b1, 3'b000, 3'd7, 3'd0, 3'd0, 3'd0, 1'b0);
    count_chk(344, "wrap_total", 3, 3, 344, 1);
    wait_cyc(344);
    rst_n = 1'b1; hold = 1'b0;
    snap(348, "restart_wait", 1'b0, 3'b000, 3'd7, 3'd0, 3'd0, 3'd0, 1'b0);
    snap(349, "restart_step", 1'b0, 3'b000, 3'd7, 3'd1, 3'd0, 3'd0, 1'b0);

    wait_cyc(351);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: %0d expectations never checked, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d, want finish by 351", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rgb_sequencer.md
Name: rgb_sequencer

Overview:
Controller that sequences the RGB LED through a continuous hue wheel by ramping per-channel PWM duty values on a fixed dwell schedule. It sits beside the board top level and replaces the single free-running red pulser: one instance drives all three rgb0 pins from one shared PWM counter. Button or board logic supplies en/hold; debug outputs expose the current phase and duties.

Parameters:
PWM_BITS, 8, duty/counter width; MAX = 2^PWM_BITS-1; legal 2..16
DWELL_TIME, 20'd500, clocks per brightness step; legal 1..2^20-1

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
en  in  1  1 = run sequence and drive LEDs; 0 = LEDs off, state frozen
hold  in  1  1 = freeze hue (no steps), PWM keeps running
rgb  out  3  [0]=red, [1]=green, [2]=blue, registered PWM outputs
duty_r  out  PWM_BITS  current red duty
duty_g  out  PWM_BITS  current green duty
duty_b  out  PWM_BITS  current blue duty
phase  out  3  current hue phase 0..5
wrap  out  1  one-cycle pulse when phase 5 -> 0

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, duty_r=MAX, duty_g=0, duty_b=0, phase=0, prescaler=0, pwm_cnt=0, rgb=3'b000, wrap=0. Reset dominates all other inputs.
- FSM: IDLE -> RUN when en=1; RUN -> IDLE when en=0. No other states.
- IDLE: rgb=000 (from the cycle after en falls); prescaler, pwm_cnt, duties and phase hold their values, so re-enabling resumes exactly where the sequence stopped.
- Prescaler (20 bit): in RUN with hold=0, counts 0..DWELL_TIME-1 and wraps. step = (prescaler==DWELL_TIME-1). With hold=1 the prescaler is frozen; if hold and the terminal count coincide, hold wins and no step occurs.
- On each step, the active channel changes by exactly 1 according to phase:
  0: G +1 (R=MAX)
  1: R -1 (G=MAX)
  2: B +1 (G=MAX)
  3: G -1 (B=MAX)
  4: R +1 (B=MAX)
  5: B -1 (R=MAX)
- Phase advance: when the step makes the ramping channel reach its endpoint (MAX for ramp-up, 0 for ramp-down), phase increments on that same clock edge; 5 wraps to 0 with wrap=1 for that cycle only. Duties never overflow or underflow. Each phase lasts MAX steps; a full wheel lasts 6*MAX*DWELL_TIME clocks.
- PWM: pwm_cnt free-runs 0..MAX-1 in RUN, period MAX. Channel output = (pwm_cnt < duty) registered, so there is 1 cycle of latency. duty=0 gives a constant 0; duty=MAX gives a constant 1.
- rgb[i] = registered compare AND (state==RUN).
- duty_*/phase outputs are the live registers, with no extra latency.

Decomposition:
- Package rgb_seq_pkg: phase encoding constants PH_R_GUP..PH_R_BDN (0..5), state encoding IDLE/RUN, channel index constants CH_R/CH_G/CH_B.
- Sub-module pwm_channel: inputs clk, rst_n, en, cnt[PWM_BITS], duty[PWM_BITS]; output is the registered compare. It is instantiated 3x and fed the shared pwm_cnt.
- Top of block: FSM, prescaler, duty ramp/phase logic, and pwm_cnt.

Test Plan:
All scenarios use PWM_BITS=3 (MAX=7) and DWELL_TIME=4.
- Reset then en=1: duty_r=7, g=0, b=0, phase=0 at reset, rgb=000. The first step lands 4 clocks after RUN entry (duty_g=1). After 7 steps (28 clocks) duty_g=7 and phase=1.
- Full wheel: run 168 clocks -> wrap pulses exactly once, for 1 cycle. phase is back to 0 with duties 7/0/0. Intermediate phases are checked at 28-clock boundaries (phase 2: R=0, G=7, B=0).
- PWM duty: freeze with hold=1 at duty_g=3 -> rgb[1] is high 3 of every 7 clocks. duty=0 gives a constant low and duty=7 a constant high, each checked over 14 clocks, including the 1-cycle output latency.
- en drop mid-phase (phase 2, duty_b=4): rgb=000 the next cycle and duties/phase frozen for 20 clocks. Re-enable -> the next step gives duty_b=5 after the remaining prescaler count.
- hold coincident with terminal prescaler count: no step occurs and the prescaler stays at 3. Releasing hold -> the step fires on the next clock.
- Synchronous reset asserted mid-phase 4 -> on the next edge all registers return to reset values (rgb=000, phase=0, duties 7/0/0), regardless of en/hold.
